hs4_rx_bridge: RTL and testbench
================================

Name: hs4_rx_bridge

Overview:
- Responder end of a four-phase return-to-zero bundled-data handshake.
- Takes req/data from an asynchronous (speed-independent) sender, synchronises req into the clock domain and captures data.
- Presents captured data on a synchronous valid/ready port, then returns ack to the sender.
- Sits at the boundary between self-timed datapath blocks (e.g. the comparator) and clocked logic.

Parameters:
- DW, 8, data width of data_i / out_data.
- SYNC, 2, req synchroniser depth in flops; minimum 2.
- TO_W, 8, timeout counter width; used only with the optional feature.

Ports:
- clk  input  1  single clock.
- rst_n  input  1  asynchronous active-low reset.
- req_i  input  1  four-phase request from the asynchronous sender; asynchronous to clk.
- data_i  input  DW  bundled data; stable from req_i rise until ack_o rise.
- ack_o  output  1  four-phase acknowledge, registered.
- out_valid  output  1  captured word available.
- out_data  output  DW  captured word, registered.
- out_ready  input  1  downstream accepts the word.
- busy  output  1  high whenever state != IDLE.
- proto_err  output  1  one-cycle pulse on a protocol violation.

Behaviour:
- Reset (rst_n=0, asynchronous): synchroniser flops=0, state=IDLE, ack_o=0, out_valid=0, out_data=0, busy=0, proto_err=0.
- Synchroniser: req_i passes through SYNC flops to give req_s. No other logic reads req_i directly.
- IDLE: ack_o=0. When req_s=1, load data_i into out_data, set out_valid=1 and go to HOLD.
- HOLD: out_valid=1 and out_data is held stable.
  - On out_valid&&out_ready: clear out_valid, set ack_o=1, go to RTZ.
  - The sender is back-pressured until downstream accepts.
- RTZ: ack_o=1. When req_s=0, clear ack_o and go to IDLE.
- Latency:
  - req_i rise to out_valid=1: SYNC+1 cycles (plus up to one cycle of synchroniser uncertainty).
  - Handshake cycle to ack_o=1: 1 cycle.
  - req_s fall to ack_o=0: 1 cycle.
- Throughput: at most one word per four-phase cycle; minimum 2*SYNC+4 clk cycles per word with out_ready held at 1.
- out_data keeps its last value after acceptance; it changes only on a capture in IDLE.
- Protocol violation: req_s falls while in HOLD (before ack_o).
  - proto_err pulses for 1 cycle.
  - The captured word is still delivered.
  - On acceptance, ack_o rises, the block enters RTZ, sees req_s=0 and drops ack_o the next cycle (1-cycle ack pulse).
- Combined condition: out_ready and a req_s fall in the same HOLD cycle is still a violation (proto_err=1); the handshake completes as above.
- out_ready while out_valid=0 is ignored.
- Reset mid-operation: all state cleared immediately and any word is lost. If req_i is still high after release, a new transaction is captured from current data_i after the synchroniser. The sender must tolerate this.
- ack_o never rises without a prior capture, and never falls while req_s=1.

Optional Feature:
- Macro: HS4_RX_TIMEOUT_EN.
- Defined:
  - Adds output port timeout_o (1 bit, reset 0) and a TO_W-bit counter.
  - The counter clears on entry to RTZ and increments each RTZ cycle while req_s=1, saturating at 2^TO_W-1.
  - timeout_o=1 while the counter is saturated; it is sticky until req_s=0, which clears both counter and flag.
  - Detects a sender stuck with req high.
- Undefined: no port, no counter; behaviour otherwise identical.

Test Plan:
- Reset, then req_i=1 with data_i=8'hA5 and out_ready=1 (SYNC=2) -> out_valid=1 and out_data=A5 three cycles after req rise; ack_o=1 one cycle after acceptance; req_i=0 -> ack_o=0 three cycles later; busy=0.
- out_ready=0 for 10 cycles after capture of 8'h3C -> out_valid=1, out_data=3C and ack_o=0 throughout; out_ready=1 -> ack_o rises next cycle.
- Four back-to-back words 01,02,03,04 with out_ready=1 -> delivered in order, no duplicates, each ack_o low before the next capture, proto_err=0.
- Drop req_i while in HOLD (word 8'h77) -> proto_err one-cycle pulse; 77 still delivered; ack_o high for exactly 1 cycle; then IDLE.
- Assert rst_n=0 during HOLD with req_i held high -> outputs 0 immediately; after release with data_i=8'h5A, new capture of 5A.
- With HS4_RX_TIMEOUT_EN and TO_W=4, hold req_i high in RTZ -> timeout_o=1 after 15 RTZ cycles; req_i=0 -> timeout_o=0 once req_s falls.

Source files
------------

// File: rtl/hs4_rx_bridge.sv
// Responder end of a four-phase return-to-zero bundled-data handshake, bridging to a valid/ready port.
// Optional stuck-request timeout enabled by defining HS4_RX_TIMEOUT_EN (adds port timeout_o).
module hs4_rx_bridge #(
    parameter int DW   = 8,
    parameter int SYNC = 2,
    parameter int TO_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_i,
    input  logic [DW-1:0] data_i,
    output logic          ack_o,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic          busy,
    output logic          proto_err
`ifdef HS4_RX_TIMEOUT_EN
    ,
    output logic          timeout_o
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RTZ  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [SYNC-1:0] sync_q, sync_d;
    logic            req_s;
    logic            req_prev_q, req_prev_d;
    logic            req_fall_s;
    logic            ack_q, ack_d;
    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic            busy_q, busy_d;
    logic            proto_err_q, proto_err_d;

    // Synchroniser shift and the one-cycle-delayed copy used to detect a req fall.
    always_comb begin
        sync_d     = {sync_q[SYNC-2:0], req_i};
        req_prev_d = req_s;
    end

    assign req_s      = sync_q[SYNC-1];
    assign req_fall_s = req_prev_q & ~req_s;

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sync_q      <= {SYNC{1'b0}};
            req_prev_q  <= 1'b0;
            ack_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= {DW{1'b0}};
            busy_q      <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            req_prev_q  <= req_prev_d;
            ack_q       <= ack_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_s) begin
                    state_d = HOLD;
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (out_valid_q && out_ready) begin
                    state_d = RTZ;
                end else begin
                    state_d = HOLD;
                end
            end
            RTZ: begin
                if (!req_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = RTZ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered output values; a req fall seen in HOLD is a violation but the word is still delivered.
    always_comb begin
        ack_d       = ack_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        proto_err_d = 1'b0;
        busy_d      = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                ack_d = 1'b0;
                if (req_s) begin
                    out_data_d  = data_i;
                    out_valid_d = 1'b1;
                end else begin
                    out_valid_d = 1'b0;
                end
            end
            HOLD: begin
                proto_err_d = req_fall_s;
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    ack_d       = 1'b1;
                end else begin
                    out_valid_d = 1'b1;
                    ack_d       = 1'b0;
                end
            end
            RTZ: begin
                out_valid_d = 1'b0;
                if (!req_s) begin
                    ack_d = 1'b0;
                end else begin
                    ack_d = 1'b1;
                end
            end
            default: begin
                ack_d       = 1'b0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    assign ack_o     = ack_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign proto_err = proto_err_q;

`ifdef HS4_RX_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_MAX = {TO_W{1'b1}};

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            timeout_q, timeout_d;

    // Counts RTZ cycles with req still high; saturation flags a stuck sender until req drops.
    always_comb begin
        to_cnt_d  = to_cnt_q;
        timeout_d = 1'b0;
        if (state_q == HOLD && state_d == RTZ) begin
            to_cnt_d = {TO_W{1'b0}};
        end else if (state_q == RTZ && req_s) begin
            if (to_cnt_q == TO_MAX) begin
                to_cnt_d = to_cnt_q;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end else begin
            to_cnt_d = {TO_W{1'b0}};
        end
        if (state_q == RTZ && req_s && to_cnt_d == TO_MAX) begin
            timeout_d = 1'b1;
        end else begin
            timeout_d = 1'b0;
        end
    end

    // Timeout counter and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q  <= {TO_W{1'b0}};
            timeout_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`endif

endmodule

// File: tb/tb_hs4_rx_bridge.sv
// Directed bench for hs4_rx_bridge: per-cycle vector table plus hand sequences for multi-cycle corners.
module tb_hs4_rx_bridge;

    logic       clk;
    logic       rst_n;
    logic       req_i;
    logic [7:0] data_i;
    logic       ack_o;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       busy;
    logic       proto_err;
`ifdef HS4_RX_TIMEOUT_EN
    logic       timeout_o;
`endif

    int tests_run = 0;
    int tests_failed = 0;
    int err_pulses = 0;

    hs4_rx_bridge #(.DW(8), .SYNC(2), .TO_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req_i),
        .data_i    (data_i),
        .ack_o     (ack_o),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .proto_err (proto_err)
`ifdef HS4_RX_TIMEOUT_EN
        ,
        .timeout_o (timeout_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (proto_err === 1'b1) err_pulses <= err_pulses + 1;
    end

    typedef struct {
        logic       req;
        logic [7:0] data;
        logic       rdy;
        logic       ack;
        logic       vld;
        logic [7:0] odata;
        logic       bsy;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic req, input logic [7:0] data, input logic rdy,
                       input logic ack, input logic vld, input logic [7:0] odata,
                       input logic bsy, input logic err);
        vec_t v;
        v.req = req; v.data = data; v.rdy = rdy;
        v.ack = ack; v.vld = vld; v.odata = odata; v.bsy = bsy; v.err = err;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits up to a cycle budget for out_valid; an expired budget counts as a failure.
    task automatic wait_valid(input string name);
        int n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({name, "_valid_seen"}, 32'(out_valid), 32'd1);
    endtask

    task automatic wait_ack_low(input string name);
        int n = 0;
        while (ack_o !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
        chk({name, "_ack_low"}, 32'(ack_o), 32'd0);
    endtask

    initial begin
        int errs_before;
        logic [7:0] words [4];

        // Word A5 with out_ready held high.
        add(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        add(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        add(1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0);
        add(1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0);
        add(1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0);
        add(1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0);
        add(1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0);
        // Word 3C back-pressured for 10 cycles.
        add(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0);
        add(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) add(1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0);
        add(1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0);
        add(1'b0, 8'h3C, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0);
        add(1'b0, 8'h3C, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0);
        add(1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0);
        // Word 77: req dropped in HOLD, accepted later, single-cycle ack.
        add(1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0);
        add(1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0);
        add(1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 8'h77, 1'b1, 1'b0);
        add(1'b0, 8'h77, 1'b0, 1'b0, 1'b1, 8'h77, 1'b1, 1'b0);
        add(1'b0, 8'h77, 1'b0, 1'b0, 1'b1, 8'h77, 1'b1, 1'b0);
        add(1'b0, 8'h77, 1'b0, 1'b0, 1'b1, 8'h77, 1'b1, 1'b1);
        add(1'b0, 8'h77, 1'b0, 1'b0, 1'b1, 8'h77, 1'b1, 1'b0);
        add(1'b0, 8'h77, 1'b1, 1'b1, 1'b0, 8'h77, 1'b1, 1'b0);
        add(1'b0, 8'h77, 1'b1, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0);
        // Word 9C: req fall and out_ready in the same HOLD cycle.
        add(1'b1, 8'h9C, 1'b0, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0);
        add(1'b1, 8'h9C, 1'b0, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0);
        add(1'b1, 8'h9C, 1'b0, 1'b0, 1'b1, 8'h9C, 1'b1, 1'b0);
        add(1'b0, 8'h9C, 1'b0, 1'b0, 1'b1, 8'h9C, 1'b1, 1'b0);
        add(1'b0, 8'h9C, 1'b0, 1'b0, 1'b1, 8'h9C, 1'b1, 1'b0);
        add(1'b0, 8'h9C, 1'b1, 1'b1, 1'b0, 8'h9C, 1'b1, 1'b1);
        add(1'b0, 8'h9C, 1'b1, 1'b0, 1'b0, 8'h9C, 1'b0, 1'b0);

        rst_n = 1'b0; req_i = 1'b0; data_i = 8'h00; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", 32'(ack_o), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(proto_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            req_i = vecs[i].req; data_i = vecs[i].data; out_ready = vecs[i].rdy;
            tick();
            chk($sformatf("v%0d_ack", i), 32'(ack_o), 32'(vecs[i].ack));
            chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vecs[i].vld));
            chk($sformatf("v%0d_data", i), 32'(out_data), 32'(vecs[i].odata));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].bsy));
            chk($sformatf("v%0d_err", i), 32'(proto_err), 32'(vecs[i].err));
        end

        // Four back-to-back words with out_ready held high.
        words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h03; words[3] = 8'h04;
        errs_before = err_pulses;
        out_ready = 1'b1;
        for (int w = 0; w < 4; w++) begin
            req_i = 1'b1; data_i = words[w];
            wait_valid($sformatf("b2b%0d", w));
            chk($sformatf("b2b%0d_data", w), 32'(out_data), 32'(words[w]));
            chk($sformatf("b2b%0d_ack_at_cap", w), 32'(ack_o), 32'd0);
            tick();
            chk($sformatf("b2b%0d_ack_hi", w), 32'(ack_o), 32'd1);
            chk($sformatf("b2b%0d_valid_lo", w), 32'(out_valid), 32'd0);
            req_i = 1'b0;
            wait_ack_low($sformatf("b2b%0d", w));
        end
        tick();
        chk("b2b_no_err", 32'(err_pulses - errs_before), 32'd0);
        chk("b2b_idle", 32'(busy), 32'd0);

        // Reset during HOLD with req still high, then recapture of 5A.
        out_ready = 1'b0; req_i = 1'b1; data_i = 8'hC3;
        wait_valid("rsthold");
        chk("rsthold_data", 32'(out_data), 32'hC3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_valid", 32'(out_valid), 32'd0);
        chk("rstmid_data", 32'(out_data), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        @(negedge clk);
        data_i = 8'h5A;
        rst_n = 1'b1;
        repeat (2) tick();
        chk("recap_not_yet", 32'(out_valid), 32'd0);
        tick();
        chk("recap_valid", 32'(out_valid), 32'd1);
        chk("recap_data", 32'(out_data), 32'h5A);
        out_ready = 1'b1;
        tick();
        chk("recap_ack", 32'(ack_o), 32'd1);
        req_i = 1'b0;
        wait_ack_low("recap");

`ifdef HS4_RX_TIMEOUT_EN
        // Stuck request: 15 RTZ cycles with req high saturate a 4-bit counter.
        req_i = 1'b1; data_i = 8'hE1; out_ready = 1'b1;
        wait_valid("to");
        tick();
        chk("to_in_rtz", 32'(ack_o), 32'd1);
        chk("to_clear_on_entry", 32'(timeout_o), 32'd0);
        repeat (14) tick();
        chk("to_not_yet", 32'(timeout_o), 32'd0);
        tick();
        chk("to_set", 32'(timeout_o), 32'd1);
        repeat (3) tick();
        chk("to_sticky", 32'(timeout_o), 32'd1);
        req_i = 1'b0;
        wait_ack_low("to");
        chk("to_cleared", 32'(timeout_o), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
